ccmp_rx_hdr_parser: RTL and testbench
=====================================

CCMP_RX_HDR_PARSER -- requirements
Module: ccmp_rx_hdr_parser

Interface
REQ-001 SHALL have a single parameter: MIC_LEN, default 8, meaning the CCMP MIC length in bytes removed from the payload length.
REQ-002 SHALL have these ports, one per line as name, direction, width, meaning:
- macCoreClk  in  1  clock.
- nPRst  in  1  reset, asynchronous, active-low.
- nSRst  in  1  software reset, synchronous, active-low.
- rxStart_p  in  1  start of a received MPDU.
- rxByteValid_p  in  1  rxByte is valid this cycle.
- rxByte  in  8  received MPDU byte, in air order.
- rxMpduLen  in  16  MPDU length in bytes, FCS included; stable from rxStart_p.
- rxError_p  in  1  abort of the reception.
- rcDestId  out  48  Address1.
- rcSourceId  out  48  Address2.
- rcSfc  out  48  packet number, {PN5,PN4,PN3,PN2,PN1,PN0}.
- rxAddress4Pres  out  1  Address4 is present.
- rxQoSFrame  out  1  QoS data frame.
- rxTID  out  4  QoS TID.
- rxQoS7  out  1  QoS control bit 7.
- rcKeyId  out  2  key ID.
- rcPayloadLen  out  16  encrypted payload length in bytes.
- hdrDone_p  out  1  header parsed; outputs valid.
- hdrError_p  out  1  header rejected.

Function
REQ-003 SHALL consume bytes only on cycles where rxByteValid_p=1. On rxByteValid_p=0 cycles, state and counters SHALL hold.
REQ-004 The FSM SHALL have the states IDLE, FC, DUR, ADDR1, ADDR2, ADDR3, SEQ, ADDR4, QOS, HTC, CCMPHDR, DONE.
REQ-005 On rxStart_p from any state, the FSM SHALL go to FC and clear the byte counter. A new rxStart_p mid-frame restarts the parse.
REQ-006 The field lengths in bytes SHALL be: FC 2, DUR 2, ADDR1 6, ADDR2 6, ADDR3 6, SEQ 2, ADDR4 6, QOS 2, HTC 4, CCMPHDR 8. A 3-bit byte counter per field SHALL reset to 0 on each state change.
REQ-007 In FC byte 0, the block SHALL latch qos = (type bits[3:2]==2'b10) && bit7.
REQ-008 In FC byte 1, the block SHALL latch a4 = bit0 && bit1 (ToDS && FromDS), and htc = bit7 (order).
REQ-009 After SEQ, the FSM SHALL go to ADDR4 if a4=1. Otherwise it SHALL go to QOS if qos=1, else to CCMPHDR.
REQ-010 After ADDR4, the FSM SHALL go to QOS if qos=1, else to CCMPHDR.
REQ-011 After QOS, the FSM SHALL go to HTC if htc=1, else to CCMPHDR.
REQ-012 Address bytes SHALL be stored first-byte-at-MSB: the first byte goes to [47:40] and the sixth byte to [7:0].
REQ-013 QOS byte 0 SHALL load rxTID=byte[3:0] and rxQoS7=byte[7]. QOS byte 1 is ignored.
REQ-014 In CCMPHDR, the bytes SHALL map as follows:
- byte 0 -> PN0, byte 1 -> PN1, byte 2 ignored.
- byte 3 -> ExtIV=bit5 and rcKeyId=bits[7:6].
- bytes 4..7 -> PN2..PN5.
REQ-015 hdrLen SHALL be 24 + 6*a4 + 2*qos + 4*(qos&&htc).
REQ-016 rcPayloadLen SHALL be rxMpduLen - hdrLen - 8 - MIC_LEN - 4, computed in 17-bit arithmetic.
REQ-017 On the cycle after the last CCMPHDR byte, the block SHALL take one of two outcomes:
- If ExtIV=1 and the REQ-016 result is >= 0, assert hdrDone_p for 1 cycle and enter DONE.
- Otherwise, assert hdrError_p for 1 cycle and go to IDLE, with rcPayloadLen forced to 0.
REQ-018 DONE SHALL ignore further bytes and hold all outputs until the next rxStart_p.
REQ-019 rxError_p SHALL return the FSM to IDLE next cycle with no hdrDone_p or hdrError_p. Outputs keep their last values.
REQ-020 If rxError_p and rxStart_p are asserted in the same cycle, rxStart_p SHALL win.
REQ-021 If rxError_p coincides with the hdrDone_p-generating cycle, hdrDone_p SHALL be suppressed.
REQ-022 The rxAddress4Pres and rxQoSFrame outputs SHALL update as soon as FC byte 1 is latched.
REQ-023 hdrDone_p and hdrError_p SHALL never both be asserted in the same cycle.

Reset
REQ-024 When nPRst=0, the block SHALL asynchronously force the FSM to IDLE and all outputs and internal registers to 0.
REQ-025 When nSRst=0 at a clock edge, the block SHALL force the same values as REQ-024.
REQ-026 Reset mid-parse SHALL discard the frame; no pulse follows.

Verification
REQ-027 Non-QoS 3-address frame, FC=08 41, rxMpduLen=60, ExtIV=1, PN bytes 01 02 xx 20 03 04 05 06 -> hdrDone_p 31 cycles after the first byte (with continuous valid bytes); rcSfc=48'h060504030201, rcPayloadLen=16, rxQoSFrame=0.
REQ-028 QoS 4-address frame, FC=88 03, QoS byte0=8'h85, rxMpduLen=100 -> hdrLen=32; rxTID=5, rxQoS7=1, rxAddress4Pres=1, rcPayloadLen=48.
REQ-029 QoS frame with order bit, FC=88 80 -> HTC 4 bytes skipped; hdrLen=30 and the PN is taken from the correct offset.
REQ-030 Key ID byte with ExtIV=0, or rxMpduLen=40 on a 3-address frame -> hdrError_p single pulse, no hdrDone_p, rcPayloadLen=0.
REQ-031 Abort and restart cases -> rxError_p at ADDR2 byte 3 gives IDLE with no pulse; rxStart_p mid-ADDR3 restarts and the parse of the second frame is correct; valid gaps of 1-5 cycles between bytes give a result identical to the gapless run.

Source files
------------

// File: rtl/ccmp_rx_hdr_parser.sv
// ---------------------------------------------------------------------------
// ccmp_rx_hdr_parser
//
// Walks the 802.11 MAC header and the CCMP header of a received MPDU, one
// byte per valid cycle, and extracts what the CCMP decryption engine needs:
// the two addresses feeding the nonce/AAD, the 48-bit packet number, the key
// ID and the length of the encrypted payload (MPDU minus MAC header, CCMP
// header, MIC and FCS).
//
// The header layout is decided by three frame-control flags latched on the
// fly: a4 (ToDS && FromDS adds Address4), qos (QoS data subtype adds the QoS
// control field) and htc (order bit adds the HT control field, only
// meaningful for QoS frames).
//
// Ports
//   macCoreClk      in   clock
//   nPRst           in   asynchronous active-low reset
//   nSRst           in   synchronous active-low software reset
//   rxStart_p       in   start of a received MPDU (restarts the parse)
//   rxByteValid_p   in   rxByte carries a byte this cycle
//   rxByte          in   MPDU byte, air order
//   rxMpduLen       in   MPDU length incl. FCS, stable from rxStart_p
//   rxError_p       in   reception aborted
//   rcDestId        out  Address1, first air byte at [47:40]
//   rcSourceId      out  Address2, first air byte at [47:40]
//   rcSfc           out  packet number {PN5..PN0}
//   rxAddress4Pres  out  Address4 present
//   rxQoSFrame      out  QoS data frame
//   rxTID           out  QoS TID
//   rxQoS7          out  QoS control bit 7
//   rcKeyId         out  key ID from the CCMP header
//   rcPayloadLen    out  encrypted payload length in bytes
//   hdrDone_p       out  one-cycle pulse, header accepted, outputs valid
//   hdrError_p      out  one-cycle pulse, header rejected
// ---------------------------------------------------------------------------
module ccmp_rx_hdr_parser #(
    parameter int MIC_LEN = 8
) (
    input  logic        macCoreClk,
    input  logic        nPRst,
    input  logic        nSRst,
    input  logic        rxStart_p,
    input  logic        rxByteValid_p,
    input  logic [7:0]  rxByte,
    input  logic [15:0] rxMpduLen,
    input  logic        rxError_p,
    output logic [47:0] rcDestId,
    output logic [47:0] rcSourceId,
    output logic [47:0] rcSfc,
    output logic        rxAddress4Pres,
    output logic        rxQoSFrame,
    output logic [3:0]  rxTID,
    output logic        rxQoS7,
    output logic [1:0]  rcKeyId,
    output logic [15:0] rcPayloadLen,
    output logic        hdrDone_p,
    output logic        hdrError_p
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FC      = 4'd1;
    localparam logic [3:0] S_DUR     = 4'd2;
    localparam logic [3:0] S_ADDR1   = 4'd3;
    localparam logic [3:0] S_ADDR2   = 4'd4;
    localparam logic [3:0] S_ADDR3   = 4'd5;
    localparam logic [3:0] S_SEQ     = 4'd6;
    localparam logic [3:0] S_ADDR4   = 4'd7;
    localparam logic [3:0] S_QOS     = 4'd8;
    localparam logic [3:0] S_HTC     = 4'd9;
    localparam logic [3:0] S_CCMPHDR = 4'd10;
    localparam logic [3:0] S_DONE    = 4'd11;

    logic [3:0]  r_state;
    logic [2:0]  r_byteCnt;
    logic        r_qos;
    logic        r_a4;
    logic        r_htc;
    logic        r_extIv;
    logic        r_qosFrame;
    logic [47:0] r_destId;
    logic [47:0] r_sourceId;
    logic [47:0] r_sfc;
    logic [3:0]  r_tid;
    logic        r_qos7;
    logic [1:0]  r_keyId;
    logic [15:0] r_payloadLen;
    logic        r_hdrDone;
    logic        r_hdrError;

    logic        w_parsing;
    logic        w_fieldLast;
    logic [3:0]  w_nextField;
    logic [5:0]  w_addrLsb;
    logic [2:0]  w_pnIdx;
    logic [5:0]  w_pnLsb;
    logic [5:0]  w_hdrLen;
    logic [16:0] w_payloadLen;
    logic        w_hdrOk;

    // Only the header states consume bytes; IDLE waits for a start and DONE
    // freezes the result until the next frame.
    assign w_parsing = (r_state >= S_FC) && (r_state <= S_CCMPHDR);

    // Byte lanes: addresses fill MSB-first, PN bytes 0,1 then 4..7 map to
    // PN0,PN1 then PN2..PN5 (bytes 2 and 3 of the CCMP header are not PN).
    assign w_addrLsb = {3'd5 - r_byteCnt, 3'b000};
    assign w_pnIdx   = (r_byteCnt < 3'd4) ? r_byteCnt : (r_byteCnt - 3'd2);
    assign w_pnLsb   = {w_pnIdx, 3'b000};

    // Header length and remaining encrypted payload; bit 16 of the 17-bit
    // difference flags an MPDU too short to hold header, MIC and FCS.
    assign w_hdrLen = 6'd24 + (r_a4 ? 6'd6 : 6'd0) + (r_qos ? 6'd2 : 6'd0)
                    + ((r_qos && r_htc) ? 6'd4 : 6'd0);
    assign w_payloadLen = {1'b0, rxMpduLen} - {11'd0, w_hdrLen} - 17'd12
                        - 17'(MIC_LEN);
    assign w_hdrOk = r_extIv && !w_payloadLen[16];

    // Last byte index of the field currently being consumed.
    always_comb begin
        w_fieldLast = 1'b0;
        case (r_state)
            S_FC, S_DUR, S_SEQ, S_QOS:     w_fieldLast = (r_byteCnt == 3'd1);
            S_ADDR1, S_ADDR2, S_ADDR3,
            S_ADDR4:                       w_fieldLast = (r_byteCnt == 3'd5);
            S_HTC:                         w_fieldLast = (r_byteCnt == 3'd3);
            S_CCMPHDR:                     w_fieldLast = (r_byteCnt == 3'd7);
            default:                       w_fieldLast = 1'b0;
        endcase
    end

    // Field sequencing; the optional fields are skipped according to the
    // frame-control flags latched during FC.
    always_comb begin
        w_nextField = S_IDLE;
        case (r_state)
            S_FC:    w_nextField = S_DUR;
            S_DUR:   w_nextField = S_ADDR1;
            S_ADDR1: w_nextField = S_ADDR2;
            S_ADDR2: w_nextField = S_ADDR3;
            S_ADDR3: w_nextField = S_SEQ;
            S_SEQ:   w_nextField = r_a4 ? S_ADDR4 : (r_qos ? S_QOS : S_CCMPHDR);
            S_ADDR4: w_nextField = r_qos ? S_QOS : S_CCMPHDR;
            S_QOS:   w_nextField = r_htc ? S_HTC : S_CCMPHDR;
            S_HTC:   w_nextField = S_CCMPHDR;
            default: w_nextField = S_IDLE;
        endcase
    end

    // Main parser. Start beats abort, abort beats byte consumption, so a
    // frame killed on its final byte never produces a pulse.
    always_ff @(posedge macCoreClk or negedge nPRst) begin
        if (!nPRst) begin
            r_state      <= S_IDLE;
            r_byteCnt    <= 3'd0;
            r_qos        <= 1'b0;
            r_a4         <= 1'b0;
            r_htc        <= 1'b0;
            r_extIv      <= 1'b0;
            r_qosFrame   <= 1'b0;
            r_destId     <= 48'd0;
            r_sourceId   <= 48'd0;
            r_sfc        <= 48'd0;
            r_tid        <= 4'd0;
            r_qos7       <= 1'b0;
            r_keyId      <= 2'd0;
            r_payloadLen <= 16'd0;
            r_hdrDone    <= 1'b0;
            r_hdrError   <= 1'b0;
        end else if (!nSRst) begin
            r_state      <= S_IDLE;
            r_byteCnt    <= 3'd0;
            r_qos        <= 1'b0;
            r_a4         <= 1'b0;
            r_htc        <= 1'b0;
            r_extIv      <= 1'b0;
            r_qosFrame   <= 1'b0;
            r_destId     <= 48'd0;
            r_sourceId   <= 48'd0;
            r_sfc        <= 48'd0;
            r_tid        <= 4'd0;
            r_qos7       <= 1'b0;
            r_keyId      <= 2'd0;
            r_payloadLen <= 16'd0;
            r_hdrDone    <= 1'b0;
            r_hdrError   <= 1'b0;
        end else begin
            r_hdrDone  <= 1'b0;
            r_hdrError <= 1'b0;
            if (rxStart_p) begin
                r_state   <= S_FC;
                r_byteCnt <= 3'd0;
            end else if (rxError_p) begin
                r_state   <= S_IDLE;
                r_byteCnt <= 3'd0;
            end else if (rxByteValid_p && w_parsing) begin
                case (r_state)
                    S_FC: begin
                        if (r_byteCnt == 3'd0) begin
                            r_qos <= (rxByte[3:2] == 2'b10) && rxByte[7];
                        end else begin
                            r_a4       <= rxByte[0] && rxByte[1];
                            r_htc      <= rxByte[7];
                            r_qosFrame <= r_qos;
                        end
                    end
                    S_ADDR1: r_destId[w_addrLsb +: 8]   <= rxByte;
                    S_ADDR2: r_sourceId[w_addrLsb +: 8] <= rxByte;
                    S_QOS: begin
                        if (r_byteCnt == 3'd0) begin
                            r_tid  <= rxByte[3:0];
                            r_qos7 <= rxByte[7];
                        end
                    end
                    S_CCMPHDR: begin
                        if (r_byteCnt == 3'd3) begin
                            r_extIv <= rxByte[5];
                            r_keyId <= rxByte[7:6];
                        end else if (r_byteCnt != 3'd2) begin
                            r_sfc[w_pnLsb +: 8] <= rxByte;
                        end
                    end
                    default: ;
                endcase

                if (w_fieldLast) begin
                    r_byteCnt <= 3'd0;
                    if (r_state == S_CCMPHDR) begin
                        // ExtIV has been latched from byte 3 by now, so the
                        // verdict is taken as the final PN byte arrives.
                        if (w_hdrOk) begin
                            r_state      <= S_DONE;
                            r_hdrDone    <= 1'b1;
                            r_payloadLen <= w_payloadLen[15:0];
                        end else begin
                            r_state      <= S_IDLE;
                            r_hdrError   <= 1'b1;
                            r_payloadLen <= 16'd0;
                        end
                    end else begin
                        r_state <= w_nextField;
                    end
                end else begin
                    r_byteCnt <= r_byteCnt + 3'd1;
                end
            end
        end
    end

    assign rcDestId       = r_destId;
    assign rcSourceId     = r_sourceId;
    assign rcSfc          = r_sfc;
    assign rxAddress4Pres = r_a4;
    assign rxQoSFrame     = r_qosFrame;
    assign rxTID          = r_tid;
    assign rxQoS7         = r_qos7;
    assign rcKeyId        = r_keyId;
    assign rcPayloadLen   = r_payloadLen;
    assign hdrDone_p      = r_hdrDone;
    assign hdrError_p     = r_hdrError;

endmodule

// File: tb/tb_ccmp_rx_hdr_parser.sv
// ---------------------------------------------------------------------------
// tb_ccmp_rx_hdr_parser
//
// Self-checking bench for ccmp_rx_hdr_parser. Frames are built as byte
// arrays; the expected outputs are derived from byte offsets inside the
// frame (header length arithmetic), independent of any state sequencing.
// ---------------------------------------------------------------------------
module tb_ccmp_rx_hdr_parser;

    localparam int MIC_LEN = 8;

    logic        macCoreClk = 1'b0;
    logic        nPRst;
    logic        nSRst;
    logic        rxStart_p;
    logic        rxByteValid_p;
    logic [7:0]  rxByte;
    logic [15:0] rxMpduLen;
    logic        rxError_p;
    logic [47:0] rcDestId;
    logic [47:0] rcSourceId;
    logic [47:0] rcSfc;
    logic        rxAddress4Pres;
    logic        rxQoSFrame;
    logic [3:0]  rxTID;
    logic        rxQoS7;
    logic [1:0]  rcKeyId;
    logic [15:0] rcPayloadLen;
    logic        hdrDone_p;
    logic        hdrError_p;

    always #5 macCoreClk = ~macCoreClk;

    ccmp_rx_hdr_parser #(.MIC_LEN(MIC_LEN)) dut (
        .macCoreClk    (macCoreClk),
        .nPRst         (nPRst),
        .nSRst         (nSRst),
        .rxStart_p     (rxStart_p),
        .rxByteValid_p (rxByteValid_p),
        .rxByte        (rxByte),
        .rxMpduLen     (rxMpduLen),
        .rxError_p     (rxError_p),
        .rcDestId      (rcDestId),
        .rcSourceId    (rcSourceId),
        .rcSfc         (rcSfc),
        .rxAddress4Pres(rxAddress4Pres),
        .rxQoSFrame    (rxQoSFrame),
        .rxTID         (rxTID),
        .rxQoS7        (rxQoS7),
        .rcKeyId       (rcKeyId),
        .rcPayloadLen  (rcPayloadLen),
        .hdrDone_p     (hdrDone_p),
        .hdrError_p    (hdrError_p)
    );

    int checks = 0;
    int errors = 0;
    int edgeCnt = 0;
    int doneCnt = 0;
    int errCnt = 0;
    int bothCnt = 0;
    int lastDoneEdge = 0;
    int firstEdge = 0;

    logic [168:0] obsAll;
    assign obsAll = {rcDestId, rcSourceId, rcSfc, rxAddress4Pres, rxQoSFrame,
                     rxTID, rxQoS7, rcKeyId, rcPayloadLen};

    // Pulse monitor, sampling 1 time unit after every rising edge.
    always @(posedge macCoreClk) begin
        #1;
        edgeCnt++;
        if (hdrDone_p === 1'b1) begin
            doneCnt++;
            lastDoneEdge = edgeCnt;
        end
        if (hdrError_p === 1'b1) errCnt++;
        if (hdrDone_p === 1'b1 && hdrError_p === 1'b1) bothCnt++;
    end

    // Frame under construction and the reference model state.
    logic [7:0]  frm [0:63];
    int          frmN;
    logic [47:0] eDest, eSrc, eSfc;
    logic        eA4, eQos, eQ7;
    logic [3:0]  eTid;
    logic [1:0]  eKey;
    logic [15:0] ePay;

    function automatic logic [168:0] expAll();
        return {eDest, eSrc, eSfc, eA4, eQos, eTid, eQ7, eKey, ePay};
    endfunction

    function automatic int hdrLenOf();
        logic q, a, h;
        q = (frm[0][3:2] == 2'b10) && frm[0][7];
        a = frm[1][0] && frm[1][1];
        h = frm[1][7];
        return 24 + (a ? 6 : 0) + (q ? 2 : 0) + ((q && h) ? 4 : 0);
    endfunction

    task automatic modelReset();
        eDest = '0; eSrc = '0; eSfc = '0; eA4 = 0; eQos = 0; eQ7 = 0;
        eTid = '0; eKey = '0; ePay = '0;
    endtask

    // Effect on the outputs of the first n bytes of frm being consumed.
    task automatic modelPrefix(input int n);
        logic q, a;
        int   hl, qosOff, c;
        q      = (frm[0][3:2] == 2'b10) && frm[0][7];
        a      = frm[1][0] && frm[1][1];
        hl     = hdrLenOf();
        qosOff = 24 + (a ? 6 : 0);
        for (int k = 0; k < n; k++) begin
            if (k == 1) begin eA4 = a; eQos = q; end
            if (k >= 4 && k < 10) eDest[8*(9-k) +: 8] = frm[k];
            if (k >= 10 && k < 16) eSrc[8*(15-k) +: 8] = frm[k];
            if (q && k == qosOff) begin eTid = frm[k][3:0]; eQ7 = frm[k][7]; end
            c = k - hl;
            if (c == 0) eSfc[7:0] = frm[k];
            if (c == 1) eSfc[15:8] = frm[k];
            if (c == 3) eKey = frm[k][7:6];
            if (c >= 4 && c < 8) eSfc[8*(c-2) +: 8] = frm[k];
        end
    endtask

    task automatic modelFinish(input int len, output logic ok);
        int hl, pay;
        hl  = hdrLenOf();
        pay = len - hl - 8 - MIC_LEN - 4;
        ok  = frm[hl+3][5] && (pay >= 0);
        ePay = ok ? 16'(pay) : 16'd0;
    endtask

    task automatic buildFrame(input logic [7:0] fc0, input logic [7:0] fc1,
                              input logic extIv, input logic [1:0] keyId,
                              input logic [47:0] pn);
        int hl;
        for (int i = 0; i < 64; i++) frm[i] = 8'($urandom);
        frm[0] = fc0;
        frm[1] = fc1;
        hl     = hdrLenOf();
        frmN   = hl + 8;
        frm[hl]   = pn[7:0];
        frm[hl+1] = pn[15:8];
        frm[hl+3] = {keyId, extIv, frm[hl+3][4:0]};
        frm[hl+4] = pn[23:16];
        frm[hl+5] = pn[31:24];
        frm[hl+6] = pn[39:32];
        frm[hl+7] = pn[47:40];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge macCoreClk);
            rxStart_p = 0; rxError_p = 0; rxByteValid_p = 0; rxByte = 8'($urandom);
        end
    endtask

    task automatic sendStart(input logic [15:0] len, input logic withErr);
        @(negedge macCoreClk);
        rxMpduLen = len; rxStart_p = 1; rxError_p = withErr; rxByteValid_p = 0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic withErr);
        @(negedge macCoreClk);
        rxStart_p = 0; rxError_p = withErr; rxByteValid_p = 1; rxByte = b;
    endtask

    task automatic driveBytes(input int from, input int to, input int gapMax);
        for (int k = from; k < to; k++) begin
            if (gapMax > 0 && k > from) idle($urandom_range(1, gapMax));
            sendByte(frm[k], 1'b0);
            if (k == 0) firstEdge = edgeCnt + 1;
        end
    endtask

    function automatic logic [47:0] randPn();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic applyStimulus(input int len, input int gapMax, output logic ok);
        sendStart(16'(len), 1'b0);
        driveBytes(0, frmN, gapMax);
        idle(4);
        modelPrefix(frmN);
        modelFinish(len, ok);
    endtask

    task automatic test_reset();
        nPRst = 0; nSRst = 1; rxStart_p = 0; rxByteValid_p = 0; rxError_p = 0;
        rxByte = 0; rxMpduLen = 0;
        modelReset();
        #12;
        checks++;
        if (obsAll !== 169'd0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", obsAll);
        end
        checks++;
        if ({hdrDone_p, hdrError_p} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_pulses: got %b expected 00", {hdrDone_p, hdrError_p});
        end
        @(negedge macCoreClk);
        nPRst = 1;
        idle(3);
        checks++;
        if (obsAll !== 169'd0 || errCnt != 0 || doneCnt != 0) begin
            errors++; $display("[TB] FAIL reset_release: got %h expected 0", obsAll);
        end
    endtask

    task automatic test_3addr();
        int d0, e0; logic ok;
        d0 = doneCnt; e0 = errCnt;
        buildFrame(8'h08, 8'h41, 1'b1, 2'd0, 48'h060504030201);
        frm[27] = 8'h20;
        applyStimulus(60, 0, ok);
        checks++;
        if (doneCnt - d0 != 1 || errCnt - e0 != 0) begin
            errors++; $display("[TB] FAIL 3addr_pulses: got done %0d err %0d expected 1 0", doneCnt - d0, errCnt - e0);
        end
        checks++;
        if (lastDoneEdge - firstEdge != 31) begin
            errors++; $display("[TB] FAIL 3addr_latency: got %0d expected 31", lastDoneEdge - firstEdge);
        end
        checks++;
        if (rcSfc !== 48'h060504030201 || rcPayloadLen !== 16'd16 || rxQoSFrame !== 1'b0) begin
            errors++; $display("[TB] FAIL 3addr_fields: got sfc %h len %0d qos %b expected 060504030201 16 0", rcSfc, rcPayloadLen, rxQoSFrame);
        end
        checks++;
        if (obsAll !== expAll()) begin
            errors++; $display("[TB] FAIL 3addr_all: got %h expected %h", obsAll, expAll());
        end
        // Trailing payload bytes must be ignored while the result is held.
        for (int i = 0; i < 6; i++) sendByte(8'($urandom), 1'b0);
        idle(3);
        checks++;
        if (obsAll !== expAll() || doneCnt - d0 != 1 || errCnt - e0 != 0) begin
            errors++; $display("[TB] FAIL done_hold: got %h expected %h", obsAll, expAll());
        end
    endtask

    task automatic test_qos_4addr();
        int d0; logic ok;
        d0 = doneCnt;
        buildFrame(8'h88, 8'h03, 1'b1, 2'($urandom), randPn());
        frm[30] = 8'h85;
        applyStimulus(100, 0, ok);
        checks++;
        if (doneCnt - d0 != 1) begin
            errors++; $display("[TB] FAIL qos4_done: got %0d expected 1", doneCnt - d0);
        end
        checks++;
        if (rxTID !== 4'd5 || rxQoS7 !== 1'b1 || rxAddress4Pres !== 1'b1 || rcPayloadLen !== 16'd48) begin
            errors++; $display("[TB] FAIL qos4_fields: got tid %0d q7 %b a4 %b len %0d expected 5 1 1 48", rxTID, rxQoS7, rxAddress4Pres, rcPayloadLen);
        end
        checks++;
        if (obsAll !== expAll()) begin
            errors++; $display("[TB] FAIL qos4_all: got %h expected %h", obsAll, expAll());
        end
    endtask

    task automatic test_qos_htc();
        int d0; logic ok; logic [47:0] pn;
        d0 = doneCnt;
        pn = randPn();
        buildFrame(8'h88, 8'h80, 1'b1, 2'd2, pn);
        applyStimulus(80, 0, ok);
        checks++;
        if (doneCnt - d0 != 1 || lastDoneEdge - firstEdge != 37) begin
            errors++; $display("[TB] FAIL htc_done: got %0d latency %0d expected 1 37", doneCnt - d0, lastDoneEdge - firstEdge);
        end
        checks++;
        if (rcSfc !== pn || rcPayloadLen !== 16'd30 || rcKeyId !== 2'd2) begin
            errors++; $display("[TB] FAIL htc_fields: got sfc %h len %0d key %0d expected %h 30 2", rcSfc, rcPayloadLen, rcKeyId, pn);
        end
        checks++;
        if (obsAll !== expAll()) begin
            errors++; $display("[TB] FAIL htc_all: got %h expected %h", obsAll, expAll());
        end
    endtask

    task automatic test_header_errors();
        int lens [5] = '{60, 60, 40, 44, 43};
        logic ext [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int okExp [5] = '{0, 1, 0, 1, 0};
        int payExp [5] = '{0, 16, 0, 0, 0};
        int d0, e0; logic ok;
        for (int i = 0; i < 5; i++) begin
            d0 = doneCnt; e0 = errCnt;
            buildFrame(8'h08, 8'h41, ext[i], 2'($urandom), randPn());
            applyStimulus(lens[i], 0, ok);
            checks++;
            if (doneCnt - d0 != okExp[i] || errCnt - e0 != 1 - okExp[i]) begin
                errors++; $display("[TB] FAIL hdrerr_pulses[%0d]: got done %0d err %0d expected %0d %0d", i, doneCnt - d0, errCnt - e0, okExp[i], 1 - okExp[i]);
            end
            checks++;
            if (rcPayloadLen !== 16'(payExp[i]) || obsAll !== expAll()) begin
                errors++; $display("[TB] FAIL hdrerr_len[%0d]: got %0d expected %0d", i, rcPayloadLen, payExp[i]);
            end
        end
    endtask

    task automatic test_abort();
        int d0, e0;
        d0 = doneCnt; e0 = errCnt;
        buildFrame(8'h08, 8'h01, 1'b1, 2'd1, randPn());
        sendStart(16'd60, 1'b0);
        driveBytes(0, 13, 0);
        sendByte(frm[13], 1'b1);
        idle(1);
        driveBytes(14, frmN, 0);
        idle(4);
        modelPrefix(13);
        checks++;
        if (doneCnt - d0 != 0 || errCnt - e0 != 0) begin
            errors++; $display("[TB] FAIL abort_pulses: got done %0d err %0d expected 0 0", doneCnt - d0, errCnt - e0);
        end
        checks++;
        if (obsAll !== expAll()) begin
            errors++; $display("[TB] FAIL abort_hold: got %h expected %h", obsAll, expAll());
        end
    endtask

    task automatic test_restart();
        int d0, e0; logic ok;
        d0 = doneCnt; e0 = errCnt;
        buildFrame(8'h88, 8'h03, 1'b1, 2'd3, randPn());
        sendStart(16'd100, 1'b0);
        driveBytes(0, 18, 0);
        modelPrefix(18);
        // The restarting start coincides with an abort; the start must win.
        buildFrame(8'h08, 8'h42, 1'b1, 2'd1, randPn());
        sendStart(16'd70, 1'b1);
        driveBytes(0, frmN, 0);
        idle(4);
        modelPrefix(frmN);
        modelFinish(70, ok);
        checks++;
        if (doneCnt - d0 != 1 || errCnt - e0 != 0 || lastDoneEdge - firstEdge != 31) begin
            errors++; $display("[TB] FAIL restart_pulses: got done %0d err %0d expected 1 0", doneCnt - d0, errCnt - e0);
        end
        checks++;
        if (obsAll !== expAll()) begin
            errors++; $display("[TB] FAIL restart_all: got %h expected %h", obsAll, expAll());
        end
    endtask

    task automatic test_gaps();
        int d0; logic ok;
        buildFrame(8'h88, 8'h83, 1'b1, 2'($urandom), randPn());
        for (int pass = 0; pass < 2; pass++) begin
            d0 = doneCnt;
            applyStimulus(120, pass == 0 ? 0 : 5, ok);
            checks++;
            if (doneCnt - d0 != 1 || obsAll !== expAll()) begin
                errors++; $display("[TB] FAIL gaps[%0d]: got %h expected %h", pass, obsAll, expAll());
            end
        end
    endtask

    task automatic test_error_on_last();
        int d0, e0;
        d0 = doneCnt; e0 = errCnt;
        buildFrame(8'h08, 8'h41, 1'b1, 2'd0, randPn());
        sendStart(16'd90, 1'b0);
        driveBytes(0, frmN - 1, 0);
        sendByte(frm[frmN-1], 1'b1);
        idle(4);
        modelPrefix(frmN - 1);
        checks++;
        if (doneCnt - d0 != 0 || errCnt - e0 != 0 || obsAll !== expAll()) begin
            errors++; $display("[TB] FAIL err_last: got done %0d err %0d out %h expected 0 0 %h", doneCnt - d0, errCnt - e0, obsAll, expAll());
        end
    endtask

    task automatic test_soft_reset();
        int d0, e0; logic ok;
        d0 = doneCnt; e0 = errCnt;
        buildFrame(8'h88, 8'h00, 1'b1, 2'd1, randPn());
        sendStart(16'd80, 1'b0);
        driveBytes(0, 20, 0);
        @(negedge macCoreClk);
        rxByteValid_p = 0; nSRst = 0;
        @(negedge macCoreClk);
        nSRst = 1;
        modelReset();
        checks++;
        if (obsAll !== 169'd0) begin
            errors++; $display("[TB] FAIL srst_clear: got %h expected 0", obsAll);
        end
        driveBytes(20, frmN, 0);
        idle(4);
        checks++;
        if (doneCnt - d0 != 0 || errCnt - e0 != 0 || obsAll !== 169'd0) begin
            errors++; $display("[TB] FAIL srst_discard: got done %0d err %0d expected 0 0", doneCnt - d0, errCnt - e0);
        end
        buildFrame(8'h08, 8'h41, 1'b1, 2'd2, randPn());
        applyStimulus(64, 0, ok);
        checks++;
        if (doneCnt - d0 != 1 || obsAll !== expAll()) begin
            errors++; $display("[TB] FAIL srst_recover: got %h expected %h", obsAll, expAll());
        end
    endtask

    task automatic test_async_reset();
        int d0, e0;
        d0 = doneCnt; e0 = errCnt;
        buildFrame(8'h08, 8'h41, 1'b1, 2'd3, randPn());
        sendStart(16'd60, 1'b0);
        driveBytes(0, 30, 0);
        #2 nPRst = 0;
        #1;
        modelReset();
        checks++;
        if (obsAll !== 169'd0) begin
            errors++; $display("[TB] FAIL prst_async: got %h expected 0", obsAll);
        end
        @(negedge macCoreClk);
        rxByteValid_p = 0; nPRst = 1;
        driveBytes(30, frmN, 0);
        idle(4);
        checks++;
        if (doneCnt - d0 != 0 || errCnt - e0 != 0 || obsAll !== 169'd0) begin
            errors++; $display("[TB] FAIL prst_discard: got done %0d err %0d expected 0 0", doneCnt - d0, errCnt - e0);
        end
    endtask

    task automatic test_random();
        int d0, e0, len, gapMax, hl; logic ok; logic [7:0] fc0;
        for (int n = 0; n < 40; n++) begin
            fc0 = 8'($urandom);
            if ($urandom_range(0, 3) != 0) fc0[3:2] = 2'b10;
            buildFrame(fc0, 8'($urandom), ($urandom_range(0, 9) != 0), 2'($urandom), randPn());
            hl     = hdrLenOf();
            len    = hl + 12 + MIC_LEN + $urandom_range(0, 40) - 6;
            gapMax = $urandom_range(0, 3);
            d0 = doneCnt; e0 = errCnt;
            applyStimulus(len, gapMax, ok);
            checks++;
            if (doneCnt - d0 != int'(ok) || errCnt - e0 != int'(!ok)) begin
                errors++; $display("[TB] FAIL rand_pulses[%0d]: got done %0d err %0d expected %0d %0d", n, doneCnt - d0, errCnt - e0, ok, !ok);
            end
            checks++;
            if (obsAll !== expAll()) begin
                errors++; $display("[TB] FAIL rand_all[%0d]: got %h expected %h", n, obsAll, expAll());
            end
            if (ok && gapMax == 0) begin
                checks++;
                if (lastDoneEdge - firstEdge != frmN - 1) begin
                    errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", n, lastDoneEdge - firstEdge, frmN - 1);
                end
            end
        end
    endtask

    task automatic checkOutput();
        checks++;
        if (bothCnt != 0) begin
            errors++; $display("[TB] FAIL both_pulses: got %0d expected 0", bothCnt);
        end
    endtask

    initial begin
        test_reset();
        test_3addr();
        test_qos_4addr();
        test_qos_htc();
        test_header_errors();
        test_abort();
        test_restart();
        test_gaps();
        test_error_on_last();
        test_soft_reset();
        test_async_reset();
        test_random();
        checkOutput();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
